// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N request channels in, one registered word out.
// master drives the requests and the downstream ready; slave is the arbiter.
interface rr_arb_mux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_sel;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a single-entry output register; one grant per cycle,
// search starts at the channel after the last winner.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int unsigned   SW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    cand;
  logic [SW-1:0]    ptr_nxt;
  logic             any;
  logic             load;
  logic [WIDTH-1:0] sel_data;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    sel_q;

  // Register accepts a new word when empty or being drained this cycle.
  assign load = (~valid_q | bus.out_ready) & ~rst;

  // First valid channel searching ptr, ptr+1, ... modulo N.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = SW'((32'(ptr) + k) % N);
      if (!any && bus.in_valid[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SW'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (load && any) bus.in_ready[grant] = 1'b1;
  end

  assign ptr_nxt = (grant == LAST) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any) begin
        valid_q <= 1'b1;
        data_q  <= sel_data;
        sel_q   <= grant;
        ptr     <= ptr_nxt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule
